// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: forwarding muxes, ALU, branch resolution and
// an iterative radix-2 multiply/divide unit that stalls the front end while it runs.
package ex_stage_pkg;
    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic        MemWrite;
        logic        Jump;
        logic        Jalr;
        logic        Branch;
        logic [3:0]  ALUControl;
        logic        ALUSrc;
        logic        MulDiv;
        logic [2:0]  funct3;
        logic [31:0] RD1;
        logic [31:0] RD2;
        logic [31:0] PC;
        logic [31:0] ImmExt;
        logic [31:0] PCPlus4;
        logic [4:0]  Rs1;
        logic [4:0]  Rs2;
        logic [4:0]  Rd;
    } idex_t;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic        MemWrite;
        logic [2:0]  funct3;
        logic [31:0] ALUResult;
        logic [31:0] WriteData;
        logic [4:0]  Rd;
        logic [31:0] PCPlus4;
        logic [31:0] ImmExt;
    } exmem_t;
endpackage

module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  idex_t       inputs,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ResultW,
    output exmem_t      outputs,
    output logic [31:0] PCTargetE,
    output logic        PCSrcE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        RegWriteE,
    output logic        BusyE
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_e;

    logic [31:0] srcA, writeData, srcB, aluResult, jalrSum, mdResult;
    logic        taken;

    always_comb begin
        case (ForwardAE)
            2'b01:   srcA = ResultW;
            2'b10:   srcA = ALUResultM;
            default: srcA = inputs.RD1;
        endcase
        case (ForwardBE)
            2'b01:   writeData = ResultW;
            2'b10:   writeData = ALUResultM;
            default: writeData = inputs.RD2;
        endcase
    end

    assign srcB = inputs.ALUSrc ? inputs.ImmExt : writeData;

    always_comb begin
        aluResult = '0;
        case (inputs.ALUControl)
            4'd0:    aluResult = srcA + srcB;
            4'd1:    aluResult = srcA - srcB;
            4'd2:    aluResult = srcA & srcB;
            4'd3:    aluResult = srcA | srcB;
            4'd4:    aluResult = srcA ^ srcB;
            4'd5:    aluResult = {31'b0, $signed(srcA) < $signed(srcB)};
            4'd6:    aluResult = {31'b0, srcA < srcB};
            4'd7:    aluResult = srcA << srcB[4:0];
            4'd8:    aluResult = srcA >> srcB[4:0];
            4'd9:    aluResult = $signed(srcA) >>> srcB[4:0];
            4'd10:   aluResult = srcB;
            default: aluResult = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (inputs.funct3)
            3'b000:  taken = (srcA == srcB);
            3'b001:  taken = (srcA != srcB);
            3'b100:  taken = ($signed(srcA) < $signed(srcB));
            3'b101:  taken = ($signed(srcA) >= $signed(srcB));
            3'b110:  taken = (srcA < srcB);
            3'b111:  taken = (srcA >= srcB);
            default: taken = 1'b0;
        endcase
    end

    assign jalrSum   = srcA + inputs.ImmExt;
    assign PCTargetE = inputs.Jalr ? (jalrSum & ~32'd1) : (inputs.PC + inputs.ImmExt);
    assign PCSrcE    = (inputs.Jump | (inputs.Branch & taken)) & ~BusyE;

    // Muldiv state. acc_q holds the product, or {remainder, quotient} while dividing.
    mdState_e    state_q, state_d;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opB_q, specVal_q;
    logic [2:0]  f3_q;
    logic        negA_q, negB_q, special_q;

    logic        entrySignedA, entrySignedB, entryNegA, entryNegB;
    logic        divZero, divOvf;
    logic [31:0] magA, magB, entrySpecVal;

    always_comb begin
        entrySignedA = 1'b1;
        entrySignedB = 1'b1;
        case (inputs.funct3)
            3'b010: entrySignedB = 1'b0;
            3'b011, 3'b101, 3'b111: begin
                entrySignedA = 1'b0;
                entrySignedB = 1'b0;
            end
            default: ;
        endcase
    end

    assign entryNegA    = entrySignedA & srcA[31];
    assign entryNegB    = entrySignedB & srcB[31];
    assign magA         = entryNegA ? -srcA : srcA;
    assign magB         = entryNegB ? -srcB : srcB;
    assign divZero      = inputs.funct3[2] & (srcB == 32'd0);
    assign divOvf       = inputs.funct3[2] & ~inputs.funct3[0] &
                          (srcA == 32'h8000_0000) & (srcB == 32'hFFFF_FFFF);
    assign entrySpecVal = divZero ? (inputs.funct3[1] ? srcA : 32'hFFFF_FFFF)
                                  : (inputs.funct3[1] ? 32'd0 : 32'h8000_0000);

    logic [32:0] mulSum, divShift;
    logic [31:0] divDiff;
    logic        divFits;
    logic [63:0] accStep;

    // Subtracting modulo 2^32 is exact when the trial fits, since the difference is below the divisor.
    assign mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opB_q} : 33'd0);
    assign divShift = acc_q[63:31];
    assign divFits  = (divShift >= {1'b0, opB_q});
    assign divDiff  = divShift[31:0] - opB_q;
    assign accStep  = f3_q[2] ? {(divFits ? divDiff : divShift[31:0]), acc_q[30:0], divFits}
                              : {mulSum, acc_q[31:1]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inputs.MulDiv) state_d = (divZero | divOvf) ? DONE : BUSY;
            BUSY:    if (cnt_q == 6'd31) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [63:0] prodFix;
    logic [31:0] quotFix, remFix, corrected;

    assign prodFix   = (negA_q ^ negB_q) ? -acc_q : acc_q;
    assign quotFix   = (negA_q ^ negB_q) ? -acc_q[31:0] : acc_q[31:0];
    assign remFix    = negA_q ? -acc_q[63:32] : acc_q[63:32];
    assign corrected = f3_q[2] ? (f3_q[1] ? remFix : quotFix)
                               : ((f3_q[1:0] == 2'b00) ? prodFix[31:0] : prodFix[63:32]);

    always_comb begin
        BusyE    = ((state_q == IDLE) & inputs.MulDiv) | (state_q == BUSY);
        mdResult = '0;
        if (state_q == DONE) mdResult = special_q ? specVal_q : corrected;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opB_q     <= '0;
            specVal_q <= '0;
            f3_q      <= '0;
            negA_q    <= 1'b0;
            negB_q    <= 1'b0;
            special_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (inputs.MulDiv) begin
                    f3_q      <= inputs.funct3;
                    negA_q    <= entryNegA;
                    negB_q    <= entryNegB;
                    opB_q     <= magB;
                    acc_q     <= {32'd0, magA};
                    cnt_q     <= '0;
                    special_q <= divZero | divOvf;
                    specVal_q <= entrySpecVal;
                end
                BUSY: begin
                    acc_q <= accStep;
                    cnt_q <= cnt_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        outputs           = '0;
        outputs.RegWrite  = inputs.RegWrite;
        outputs.ResultSrc = inputs.ResultSrc;
        outputs.MemWrite  = inputs.MemWrite;
        outputs.funct3    = inputs.funct3;
        outputs.ALUResult = inputs.MulDiv ? mdResult : aluResult;
        outputs.WriteData = writeData;
        outputs.Rd        = inputs.Rd;
        outputs.PCPlus4   = inputs.PCPlus4;
        outputs.ImmExt    = inputs.ImmExt;
    end

    assign Rs1E      = inputs.Rs1;
    assign Rs2E      = inputs.Rs2;
    assign RdE       = inputs.Rd;
    assign RegWriteE = inputs.RegWrite;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected values are queued when a step is driven and
// popped when the DUT output for that step is sampled on the falling edge.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    idex_t       inp;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] aluResultM, resultW;
    exmem_t      outp;
    logic [31:0] pcTarget;
    logic        pcSrc;
    logic [4:0]  rs1E, rs2E, rdE;
    logic        regWriteE, busyE;

    int          checks = 0;
    int          failures = 0;
    string       tagQ[$];
    logic [31:0] valQ[$];

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .inputs(inp),
        .ForwardAE(fwdA), .ForwardBE(fwdB),
        .ALUResultM(aluResultM), .ResultW(resultW),
        .outputs(outp), .PCTargetE(pcTarget), .PCSrcE(pcSrc),
        .Rs1E(rs1E), .Rs2E(rs2E), .RdE(rdE),
        .RegWriteE(regWriteE), .BusyE(busyE)
    );

    task automatic expectValue(input string tag, input logic [31:0] v);
        tagQ.push_back(tag);
        valQ.push_back(v);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        checks++;
        if (tagQ.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0x%08h expected=none", obs);
        end else begin
            tag = tagQ.pop_front();
            exp = valQ.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        inp        = '0;
        fwdA       = 2'b00;
        fwdB       = 2'b00;
        aluResultM = '0;
        resultW    = '0;
    endtask

    // Drives one M op and follows it to DONE; perturb swaps the forwarded source mid-flight.
    task automatic runMulDiv(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expRes,
                             input int expBusy, input bit perturb);
        int busy;
        bit done;
        applyStimulus();
        inp.MulDiv = 1'b1;
        inp.funct3 = f3;
        inp.RD1    = a;
        inp.RD2    = b;
        if (perturb) begin
            inp.RD1    = 32'hDEAD_BEEF;
            fwdA       = 2'b10;
            aluResultM = a;
        end
        expectValue(tag, expRes);
        expectValue({tag, "_busy"}, expBusy);
        busy = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (busyE) begin
                busy++;
                if (perturb && busy == 4) begin
                    aluResultM = 32'h1234_5678;
                    fwdA       = 2'b01;
                    resultW    = 32'h0BAD_F00D;
                end
            end else begin
                done = 1'b1;
            end
        end
        checkOutput(outp.ALUResult);
        checkOutput(busy);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busy;
        reset      = 1'b1;
        inp        = '0;
        fwdA       = 2'b00;
        fwdB       = 2'b00;
        aluResultM = '0;
        resultW    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expectValue("rst_busy", 32'd0);   checkOutput({31'b0, busyE});
        expectValue("rst_alu", 32'd0);    checkOutput(outp.ALUResult);
        expectValue("rst_pcsrc", 32'd0);  checkOutput({31'b0, pcSrc});
        inp.MulDiv = 1'b1;
        inp.Jump   = 1'b1;
        #1;
        expectValue("idle_md_busy", 32'd1);       checkOutput({31'b0, busyE});
        expectValue("busy_blocks_pcsrc", 32'd0);  checkOutput({31'b0, pcSrc});

        applyStimulus();
        reset        = 1'b0;
        inp.RD1      = 32'd5;
        fwdB         = 2'b10;
        aluResultM   = 32'd7;
        inp.Rs1      = 5'd1;
        inp.Rs2      = 5'd2;
        inp.Rd       = 5'd3;
        inp.RegWrite = 1'b1;
        @(negedge clk);
        expectValue("add_result", 32'd12);  checkOutput(outp.ALUResult);
        expectValue("add_wdata", 32'd7);    checkOutput(outp.WriteData);
        expectValue("hazard_regs", {16'd0, 1'b1, rs1E == 5'd1, rs2E == 5'd2, rdE == 5'd3, 10'd3});
        checkOutput({16'd0, regWriteE, rs1E == 5'd1, rs2E == 5'd2, rdE == 5'd3, 5'd0, outp.Rd});

        applyStimulus();
        inp.ALUControl = 4'd9;
        inp.ALUSrc     = 1'b1;
        inp.RD1        = 32'h8000_0000;
        inp.ImmExt     = 32'd4;
        @(negedge clk);
        expectValue("sra", 32'hF800_0000);  checkOutput(outp.ALUResult);

        applyStimulus();
        inp.ALUControl = 4'd5;
        inp.RD1        = 32'hFFFF_FFFF;
        inp.RD2        = 32'd1;
        @(negedge clk);
        expectValue("slt", 32'd1);  checkOutput(outp.ALUResult);
        inp.ALUControl = 4'd6;
        #1;
        expectValue("sltu", 32'd0); checkOutput(outp.ALUResult);

        applyStimulus();
        inp.ALUControl = 4'd10;
        inp.ALUSrc     = 1'b1;
        inp.ImmExt     = 32'h1234_5000;
        @(negedge clk);
        expectValue("lui", 32'h1234_5000);  checkOutput(outp.ALUResult);
        inp.ALUControl = 4'd15;
        #1;
        expectValue("unused_op", 32'd0);    checkOutput(outp.ALUResult);

        applyStimulus();
        inp.Branch     = 1'b1;
        inp.funct3     = 3'b100;
        inp.ALUControl = 4'd1;
        inp.RD1        = 32'hFFFF_FFFF;
        inp.RD2        = 32'd1;
        inp.PC         = 32'h100;
        inp.ImmExt     = 32'h20;
        @(negedge clk);
        expectValue("blt_pcsrc", 32'd1);     checkOutput({31'b0, pcSrc});
        expectValue("blt_target", 32'h120);  checkOutput(pcTarget);
        inp.funct3 = 3'b110;
        #1;
        expectValue("bltu_pcsrc", 32'd0);    checkOutput({31'b0, pcSrc});
        inp.funct3 = 3'b101;
        #1;
        expectValue("bge_pcsrc", 32'd0);     checkOutput({31'b0, pcSrc});

        applyStimulus();
        inp.Branch = 1'b1;
        inp.funct3 = 3'b000;
        inp.RD1    = 32'd5;
        fwdB       = 2'b01;
        resultW    = 32'd5;
        @(negedge clk);
        expectValue("beq_fwdw_pcsrc", 32'd1);  checkOutput({31'b0, pcSrc});

        applyStimulus();
        inp.Jump   = 1'b1;
        inp.Jalr   = 1'b1;
        inp.ALUSrc = 1'b1;
        inp.RD1    = 32'h103;
        inp.PC     = 32'h400;
        @(negedge clk);
        expectValue("jalr_target", 32'h102);  checkOutput(pcTarget);
        expectValue("jalr_pcsrc", 32'd1);     checkOutput({31'b0, pcSrc});

        runMulDiv("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        runMulDiv("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        runMulDiv("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0);
        runMulDiv("mul_b2b", 3'b000, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 33, 1'b0);
        runMulDiv("div_b2b", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        runMulDiv("rem",     3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        runMulDiv("rem_pos", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
        runMulDiv("divu",    3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        runMulDiv("remu",    3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        runMulDiv("divu_big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        runMulDiv("div_zero", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        runMulDiv("rem_zero", 3'b110, 32'd13, 32'd0, 32'd13, 1, 1'b0);
        runMulDiv("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        runMulDiv("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        runMulDiv("mul_fwd_change", 3'b000, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 33, 1'b1);

        // Abort a multiply part way through BUSY and confirm the unit is idle afterwards.
        applyStimulus();
        inp.MulDiv = 1'b1;
        inp.RD1    = 32'd3;
        inp.RD2    = 32'd5;
        busy = 0;
        for (int i = 0; i < 40 && busy < 11; i++) begin
            @(negedge clk);
            if (busyE) busy++;
        end
        reset      = 1'b1;
        inp.MulDiv = 1'b0;
        inp.RD1    = 32'd1;
        inp.RD2    = 32'd2;
        @(negedge clk);
        expectValue("rstmid_busy", 32'd0);  checkOutput({31'b0, busyE});
        expectValue("rstmid_alu", 32'd3);   checkOutput(outp.ALUResult);
        @(posedge clk);
        #1;
        reset = 1'b0;
        runMulDiv("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
